cordic_sched: RTL and testbench
===============================

Name: cordic_sched

Overview:
- Shares one fixed-latency pipelined CORDIC core among NREQ requesters.
- Per cycle: round-robin arbitration of angle requests and at most one issue to the core.
- Tracks requester id and quadrant flag alongside the core pipeline.
- Returns each sin/cos result tagged with its requester id. Sits between angle-producing blocks (NCO, rotators) and the core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, core output magnitude bits; result ports are WIDTH+1 signed.
- CORE_LAT, 32, core latency in cycles from i_theta capture to valid o_cosine/o_sine.
- IDW, $clog2(NREQ), requester id width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_en  in  1  arbitration enable; low = no new grants, in-flight results still drain.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_theta  in  NREQ*32  per-requester angle, signed Q16.16 radians, slice i = bits [32i+31:32i].
- o_req_ready  out  NREQ  one-hot grant; request i accepted when i_req_valid[i] & o_req_ready[i].
- o_core_theta  out  32  signed Q16.16 angle to core.
- o_core_valid  out  1  issue strobe (core ignores it; used for tag tracking and debug).
- i_core_cos  in  WIDTH+1  core cosine output.
- i_core_sin  in  WIDTH+1  core sine output.
- o_rsp_valid  out  1  result strobe, one cycle; no backpressure.
- o_rsp_id  out  IDW  requester id of result.
- o_rsp_cos  out  WIDTH+1  signed cosine.
- o_rsp_sin  out  WIDTH+1  signed sine.
- o_busy  out  1  high while any tag is in flight.

Behaviour:
- Reset (i_rst_n low at posedge): o_core_theta=0, o_core_valid=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_cos=0, o_rsp_sin=0, o_busy=0, round-robin pointer=0, all tag-pipe valids cleared.
- Reset mid-operation: in-flight results are dropped, never presented.
- Arbiter: o_req_ready is combinational from i_req_valid, i_en and pointer. It is one-hot or zero, and is zero when i_en=0 or in reset.
- Priority order: starts at pointer, ascending, wrapping at NREQ-1 -> 0.
- On accept of index g: pointer <= (g+1) mod NREQ. With no accept, pointer holds.
- Issue: acceptance at edge t registers o_core_theta (after folding) and o_core_valid=1, visible in cycle t+1. With no accept: o_core_valid=0 and o_core_theta holds its last value.
- Tag pipe: shift register of {valid, id, neg}, depth CORE_LAT. Loaded alongside the issue register, advances every cycle, and aligns with core output.
- Response: registered. Visible CORE_LAT+1 cycles after o_core_valid, so total accept-to-response latency is CORE_LAT+2 cycles.
- Sustained throughput: 1 result/cycle.
- neg=1: o_rsp_cos=-i_core_cos and o_rsp_sin=-i_core_sin. -2^WIDTH saturates to 2^WIDTH-1.
- Responses with valid=0 leave o_rsp_id, o_rsp_cos and o_rsp_sin unchanged.
- o_busy = OR of tag-pipe valids and the issue register valid.
- Simultaneous requests: exactly one grant per cycle. Other requesters hold valid and theta stable until granted.
- i_en falling: current combinational grant is withdrawn the same cycle, and nothing is accepted.

Optional Feature:
- Macro CORDIC_QUAD_FOLD_EN.
- Defined: input range [-PI, PI).
  - theta > PI_2: core theta = theta-PI, neg=1.
  - theta < -PI_2: core theta = theta+PI, neg=1.
  - Otherwise pass through, neg=0.
- Undefined: theta passes unchanged, neg is always 0, negation and saturation logic is omitted. Requesters must keep |theta| <= PI_2.

Decomposition:
- Package cordic_pkg:
  - THETA_W=32.
  - PI=32'h0003243F.
  - PI_2=32'h0001921F.
  - typedef cordic_tag_t {logic valid; logic [IDW-1:0] id; logic neg;} (id width via parameterised struct or max width 3).
- One sub-module: cordic_tag_pipe (depth-parameterised shift register of cordic_tag_t, synchronous active-low clear).
- Arbiter stays inline.

Test Plan:
- Reset: hold i_rst_n low 3 cycles with all valids high -> o_req_ready=0 and all outputs 0. Release -> first grant is index 0.
- Round-robin: NREQ=4, all valid continuously -> grant order 0,1,2,3,0,...; o_rsp_id follows the same order.
- Latency: behavioural core stub CORE_LAT=32 returning cos=0x0ABCD, sin=0x01234. Single request at cycle 10 -> o_rsp_valid at cycle 44 only, with the same values.
- Fold (CORDIC_QUAD_FOLD_EN): theta=0x00030000 (3.0 rad) -> o_core_theta=0xFFFFDBC1; stub returns cos=0x0FD00, sin=0x00242 -> o_rsp_cos=-0x0FD00, o_rsp_sin=-0x00242.
- Fold saturation: stub returns cos=-65536 (0x10000) with neg=1 -> o_rsp_cos=0x0FFFF.
- Mid-flight reset: issue 5 requests, assert reset at cycle 20 for 1 cycle -> no o_rsp_valid until the next accepted request completes; o_busy=0 immediately after reset.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and the tag record carried alongside the CORDIC core pipeline.
// Angles are signed Q16.16 radians.
package cordic_pkg;

   localparam int THETA_W  = 32;
   localparam int ID_MAX_W = 3;

   localparam logic signed [THETA_W-1:0] PI   = 32'sh0003243F;
   localparam logic signed [THETA_W-1:0] PI_2 = 32'sh0001921F;

   // The id field is sized for the largest supported NREQ (8); narrower builds use the low bits.
   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
      logic                neg;
   } cordic_tag_t;

endpackage

// File: rtl/cordic_tag_pipe.sv
// cordic_tag_pipe: DEPTH-stage shift register of cordic_tag_t that tracks issued angles
// through the core so each core output can be paired with its requester id and quadrant flag.
module cordic_tag_pipe
   import cordic_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic        i_clk,
   input  logic        i_clr_n,
   input  cordic_tag_t i_tag,
   output cordic_tag_t o_tag,
   output logic        o_any_valid
);

   cordic_tag_t stage [DEPTH];

   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign o_tag = stage[DEPTH-1];

   always_comb begin
      o_any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | stage[i].valid;
   end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one fixed-latency CORDIC core among NREQ requesters.
// Define CORDIC_QUAD_FOLD_EN to fold |theta| > PI_2 into the core range and negate the result.
module cordic_sched
   import cordic_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 16,
   parameter int CORE_LAT = 32,
   parameter int IDW      = $clog2(NREQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_en,
   input  logic [NREQ-1:0]           i_req_valid,
   input  logic [NREQ*THETA_W-1:0]   i_req_theta,
   output logic [NREQ-1:0]           o_req_ready,
   output logic [THETA_W-1:0]        o_core_theta,
   output logic                      o_core_valid,
   input  logic [WIDTH:0]            i_core_cos,
   input  logic [WIDTH:0]            i_core_sin,
   output logic                      o_rsp_valid,
   output logic [IDW-1:0]            o_rsp_id,
   output logic [WIDTH:0]            o_rsp_cos,
   output logic [WIDTH:0]            o_rsp_sin,
   output logic                      o_busy
);

   // Handshake: request i transfers on a rising edge where i_req_valid[i] & o_req_ready[i];
   // an unserved requester keeps valid and theta stable. Responses have no backpressure.

   logic [IDW-1:0]             ptr;
   logic [IDW-1:0]             gidx;
   logic [IDW-1:0]             scan_idx;
   logic                       gfound;
   logic                       accept;
   logic signed [THETA_W-1:0]  sel_theta;
   logic signed [THETA_W-1:0]  fold_theta;
   logic                       fold_neg;
   cordic_tag_t                next_tag;
   cordic_tag_t                iss_tag;
   cordic_tag_t                core_tag;
   logic                       pipe_busy;
   logic                       unused_tag;

   // Scan from the farthest offset back to the pointer so the nearest valid requester wins.
   always_comb begin
      gidx     = '0;
      gfound   = 1'b0;
      scan_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = IDW'((int'(ptr) + k) % NREQ);
         if (i_req_valid[scan_idx]) begin
            gfound = 1'b1;
            gidx   = scan_idx;
         end
      end
   end

   assign accept      = gfound & i_en & i_rst_n;
   assign o_req_ready = accept ? (NREQ'(1) << gidx) : '0;
   assign sel_theta   = i_req_theta[int'(gidx)*THETA_W +: THETA_W];

   always_comb begin
      fold_theta = sel_theta;
      fold_neg   = 1'b0;
`ifdef CORDIC_QUAD_FOLD_EN
      if (sel_theta > PI_2) begin
         fold_theta = sel_theta - PI;
         fold_neg   = 1'b1;
      end else if (sel_theta < -PI_2) begin
         fold_theta = sel_theta + PI;
         fold_neg   = 1'b1;
      end
`endif
   end

   always_comb begin
      next_tag       = '0;
      next_tag.valid = accept;
      next_tag.id    = ID_MAX_W'(gidx);
      next_tag.neg   = fold_neg;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ptr          <= '0;
         iss_tag      <= '0;
         o_core_theta <= '0;
      end else begin
         iss_tag <= next_tag;
         if (accept) begin
            o_core_theta <= fold_theta;
            ptr          <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
         end
      end
   end

   assign o_core_valid = iss_tag.valid;

   // The issue register is stage 0; the pipe adds CORE_LAT stages to line up with core output.
   cordic_tag_pipe #(
      .DEPTH (CORE_LAT)
   ) u_tag_pipe (
      .i_clk       (i_clk),
      .i_clr_n     (i_rst_n),
      .i_tag       (iss_tag),
      .o_tag       (core_tag),
      .o_any_valid (pipe_busy)
   );

   assign o_busy     = iss_tag.valid | pipe_busy;
   assign unused_tag = ^{core_tag.id, core_tag.neg};

`ifdef CORDIC_QUAD_FOLD_EN
   function automatic logic [WIDTH:0] neg_sat(input logic [WIDTH:0] x);
      if (x == {1'b1, {WIDTH{1'b0}}}) return {1'b0, {WIDTH{1'b1}}};
      return -x;
   endfunction
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_rsp_cos   <= '0;
         o_rsp_sin   <= '0;
      end else begin
         o_rsp_valid <= core_tag.valid;
         if (core_tag.valid) begin
            o_rsp_id <= core_tag.id[IDW-1:0];
`ifdef CORDIC_QUAD_FOLD_EN
            o_rsp_cos <= core_tag.neg ? neg_sat(i_core_cos) : i_core_cos;
            o_rsp_sin <= core_tag.neg ? neg_sat(i_core_sin) : i_core_sin;
`else
            o_rsp_cos <= i_core_cos;
            o_rsp_sin <= i_core_sin;
`endif
         end
      end
   end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: self-checking bench for cordic_sched with a behavioural core stub and
// a cycle-level reference model; honours CORDIC_QUAD_FOLD_EN when defined.
module tb_cordic_sched;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 16;
   localparam int CORE_LAT = 32;
   localparam int IDW      = 2;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic                 i_en;
   logic [NREQ-1:0]      i_req_valid;
   logic [NREQ*32-1:0]   i_req_theta;
   logic [NREQ-1:0]      o_req_ready;
   logic [31:0]          o_core_theta;
   logic                 o_core_valid;
   logic [WIDTH:0]       i_core_cos;
   logic [WIDTH:0]       i_core_sin;
   logic                 o_rsp_valid;
   logic [IDW-1:0]       o_rsp_id;
   logic [WIDTH:0]       o_rsp_cos;
   logic [WIDTH:0]       o_rsp_sin;
   logic                 o_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   cordic_sched #(
      .NREQ(NREQ), .WIDTH(WIDTH), .CORE_LAT(CORE_LAT), .IDW(IDW)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
      .i_req_valid(i_req_valid), .i_req_theta(i_req_theta), .o_req_ready(o_req_ready),
      .o_core_theta(o_core_theta), .o_core_valid(o_core_valid),
      .i_core_cos(i_core_cos), .i_core_sin(i_core_sin),
      .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
      .o_rsp_cos(o_rsp_cos), .o_rsp_sin(o_rsp_sin), .o_busy(o_busy)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural core stub ----------------
   logic        stub_fixed = 1'b0;
   logic [16:0] stub_cos   = '0;
   logic [16:0] stub_sin   = '0;
   logic [31:0] stub_pipe [CORE_LAT];

   function automatic logic [16:0] hash_cos(input logic [31:0] t);
      return t[16:0] ^ 17'h15A5A;
   endfunction

   function automatic logic [16:0] hash_sin(input logic [31:0] t);
      return t[31:15];
   endfunction

   always @(posedge i_clk) begin
      stub_pipe[0] <= o_core_theta;
      for (int k = 1; k < CORE_LAT; k++) stub_pipe[k] <= stub_pipe[k-1];
   end

   always_comb begin
      i_core_cos = stub_fixed ? stub_cos : hash_cos(stub_pipe[CORE_LAT-1]);
      i_core_sin = stub_fixed ? stub_sin : hash_sin(stub_pipe[CORE_LAT-1]);
   end

   // ---------------- reference model helpers ----------------
   function automatic void fold_model(input logic [31:0] t, output logic [31:0] ft, output bit ng);
      ft = t;
      ng = 1'b0;
`ifdef CORDIC_QUAD_FOLD_EN
      begin
         int ti;
         ti = int'($signed(t));
         if (ti > 102943) begin
            ft = 32'(ti - 205887);
            ng = 1'b1;
         end else if (ti < -102943) begin
            ft = 32'(ti + 205887);
            ng = 1'b1;
         end
      end
`endif
   endfunction

   function automatic logic [16:0] neg_model(input logic [16:0] x);
      int v;
      v = -int'($signed(x));
      if (v > 65535) v = 65535;
      return 17'(v);
   endfunction

   function automatic logic [31:0] rand_theta();
      int r;
`ifdef CORDIC_QUAD_FOLD_EN
      case ($urandom_range(0, 9))
         0: r = 102943;
         1: r = 102944;
         2: r = -102943;
         3: r = -102944;
         4: r = -205887;
         default: r = int'($urandom_range(0, 411773)) - 205887;
      endcase
`else
      case ($urandom_range(0, 9))
         0: r = 102943;
         1: r = -102943;
         2: r = 0;
         default: r = int'($urandom_range(0, 205886)) - 102943;
      endcase
`endif
      return 32'(r);
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int          due;
      logic [1:0]  id;
      logic [16:0] cos;
      logic [16:0] sin;
   } exp_t;

   exp_t        exp_q[$];
   bit          known = 1'b0;
   int          m_ptr = 0;
   logic        m_core_valid = 1'b0;
   logic [31:0] m_core_theta = '0;
   logic [1:0]  m_rsp_id = '0;
   logic [16:0] m_rsp_cos = '0;
   logic [16:0] m_rsp_sin = '0;
   logic [3:0]  m_grant;
   int          m_gi;
   int          m_j;
   bit          m_found;
   bit          m_rv;
   logic [31:0] m_ft;
   bit          m_ng;
   logic [16:0] m_c;
   logic [16:0] m_s;

   always @(negedge i_clk) begin
      if (known) begin
         m_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         if (m_rv) begin
            m_rsp_id  = exp_q[0].id;
            m_rsp_cos = exp_q[0].cos;
            m_rsp_sin = exp_q[0].sin;
            void'(exp_q.pop_front());
         end
         chk("rsp_valid", o_rsp_valid, m_rv);
         chk("rsp_id", o_rsp_id, m_rsp_id);
         chk("rsp_cos", o_rsp_cos, m_rsp_cos);
         chk("rsp_sin", o_rsp_sin, m_rsp_sin);
         chk("busy", o_busy, exp_q.size() > 0);
         chk("core_valid", o_core_valid, m_core_valid);
         chk("core_theta", o_core_theta, m_core_theta);
      end
      m_grant = '0;
      m_found = 1'b0;
      m_gi    = 0;
      if (i_rst_n && i_en) begin
         for (int k = 0; k < NREQ; k++) begin
            m_j = (m_ptr + k) % NREQ;
            if (!m_found && i_req_valid[m_j]) begin
               m_found = 1'b1;
               m_gi    = m_j;
               m_grant[m_j] = 1'b1;
            end
         end
      end
      if (known || !i_rst_n) chk("grant", o_req_ready, m_grant);
      m_core_valid = 1'b0;
      if (!i_rst_n) begin
         exp_q.delete();
         m_ptr        = 0;
         m_core_theta = '0;
         m_rsp_id     = '0;
         m_rsp_cos    = '0;
         m_rsp_sin    = '0;
         known        = 1'b1;
      end else if (m_found) begin
         fold_model(i_req_theta[m_gi*32 +: 32], m_ft, m_ng);
         m_c = stub_fixed ? stub_cos : hash_cos(m_ft);
         m_s = stub_fixed ? stub_sin : hash_sin(m_ft);
         if (m_ng) begin
            m_c = neg_model(m_c);
            m_s = neg_model(m_s);
         end
         exp_q.push_back('{cyc + CORE_LAT + 2, 2'(m_gi), m_c, m_s});
         m_core_theta = m_ft;
         m_core_valid = 1'b1;
         m_ptr = (m_gi + 1) % NREQ;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge i_clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   task automatic single(input int idx, input logic [31:0] th, input logic [31:0] exp_th,
                         input logic [16:0] ec, input logic [16:0] es);
      int acc_c, seen_c, nseen;
      @(posedge i_clk); #1;
      i_req_valid[idx] = 1'b1;
      i_req_theta[idx*32 +: 32] = th;
      @(negedge i_clk);
      chk("single_grant", o_req_ready, 4'b0001 << idx);
      acc_c = cyc;
      @(posedge i_clk); #1;
      i_req_valid[idx] = 1'b0;
      @(negedge i_clk);
      chk("issue_valid", o_core_valid, 1'b1);
      chk("issue_theta", o_core_theta, exp_th);
      nseen  = 0;
      seen_c = -1;
      repeat (CORE_LAT + 8) begin
         @(negedge i_clk);
         if (o_rsp_valid) begin
            nseen++;
            seen_c = cyc;
            if (nseen == 1) begin
               chk("single_id", o_rsp_id, idx);
               chk("single_cos", o_rsp_cos, ec);
               chk("single_sin", o_rsp_sin, es);
            end
         end
      end
      chk("single_count", nseen, 1);
      chk("single_latency", seen_c, acc_c + CORE_LAT + 2);
      @(posedge i_clk); #1;
   endtask

   typedef struct {
      logic       en;
      logic [3:0] valid;
      logic [3:0] grant;
   } vec_t;

   vec_t       tbl [10];
   logic [3:0] acc;
   int         nq;

   // ---------------- test sequence ----------------
   initial begin
      tbl[0] = '{1'b1, 4'b1111, 4'b0001};
      tbl[1] = '{1'b1, 4'b1111, 4'b0010};
      tbl[2] = '{1'b1, 4'b0001, 4'b0001};
      tbl[3] = '{1'b0, 4'b1111, 4'b0000};
      tbl[4] = '{1'b1, 4'b1000, 4'b1000};
      tbl[5] = '{1'b1, 4'b0110, 4'b0010};
      tbl[6] = '{1'b1, 4'b0000, 4'b0000};
      tbl[7] = '{1'b1, 4'b1011, 4'b1000};
      tbl[8] = '{1'b1, 4'b1100, 4'b0100};
      tbl[9] = '{1'b1, 4'b0111, 4'b0001};

      i_rst_n     = 1'b0;
      i_en        = 1'b1;
      i_req_valid = '1;
      for (int i = 0; i < NREQ; i++) i_req_theta[i*32 +: 32] = rand_theta();

      // reset held three cycles with every requester valid
      for (int n = 0; n < 3; n++) begin
         @(negedge i_clk);
         chk("rst_ready", o_req_ready, 4'b0000);
      end
      chk("rst_outs", {o_core_theta, o_core_valid, o_rsp_valid, o_rsp_id, o_busy}, '0);
      chk("rst_data", {o_rsp_cos, o_rsp_sin}, '0);

      // release: round-robin from index 0 with everyone asking
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge i_clk);
         chk("rr_grant", o_req_ready, 4'b0001 << (n % 4));
      end
      @(posedge i_clk); #1;
      i_req_valid = '0;
      drain();

      // table-driven arbitration from a freshly reset pointer
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      for (int r = 0; r < 10; r++) begin
         i_en        = tbl[r].en;
         i_req_valid = tbl[r].valid;
         for (int i = 0; i < NREQ; i++) i_req_theta[i*32 +: 32] = rand_theta();
         @(negedge i_clk);
         chk("tbl_grant", o_req_ready, tbl[r].grant);
         @(posedge i_clk); #1;
      end
      i_en        = 1'b1;
      i_req_valid = '0;
      drain();

      // fixed-latency single transaction
      stub_fixed = 1'b1;
      stub_cos   = 17'h0ABCD;
      stub_sin   = 17'h01234;
      repeat (10) @(posedge i_clk);
      single(2, 32'h00008000, 32'h00008000, 17'h0ABCD, 17'h01234);

      // quadrant folding, boundary and saturation
      stub_cos = 17'h0FD00;
      stub_sin = 17'h00242;
      single(3, 32'h0001921F, 32'h0001921F, 17'h0FD00, 17'h00242);
`ifdef CORDIC_QUAD_FOLD_EN
      single(1, 32'h00030000, 32'hFFFFDBC1, 17'h10300, 17'h1FDBE);
      single(2, 32'h00019220, 32'hFFFE6DE1, 17'h10300, 17'h1FDBE);
      stub_cos = 17'h10000;
      stub_sin = 17'h00001;
      single(0, 32'hFFFD0000, 32'h0000243F, 17'h0FFFF, 17'h1FFFF);
`else
      stub_cos = 17'h10000;
      stub_sin = 17'h00001;
      single(0, 32'hFFFE6DE1, 32'hFFFE6DE1, 17'h10000, 17'h00001);
`endif

      // reset while five results are in flight
      stub_fixed  = 1'b0;
      i_req_valid = '1;
      repeat (5) @(posedge i_clk);
      #1;
      i_req_valid = '0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("midrst_busy", o_busy, 1'b0);
      chk("midrst_core_valid", o_core_valid, 1'b0);
      nq = 0;
      repeat (CORE_LAT + 10) begin
         @(negedge i_clk);
         if (o_rsp_valid) nq++;
      end
      chk("midrst_quiet", nq, 0);
      stub_fixed = 1'b1;
      stub_cos   = 17'h00777;
      stub_sin   = 17'h1F000;
      single(3, 32'h00001000, 32'h00001000, 17'h00777, 17'h1F000);
      stub_fixed = 1'b0;

      // randomized traffic; unserved requesters hold valid and theta
      acc = '0;
      repeat (400) begin
         @(posedge i_clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (!i_req_valid[i] || acc[i]) begin
               i_req_valid[i] = ($urandom_range(0, 2) != 0);
               i_req_theta[i*32 +: 32] = rand_theta();
            end
         end
         i_en = ($urandom_range(0, 9) != 0);
         @(negedge i_clk);
         acc = o_req_ready & i_req_valid;
      end
      @(posedge i_clk); #1;
      i_req_valid = '0;
      i_en        = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
